// File: rtl/adc_lockin_rx.sv
// Lock-in receiver: phase-locks to the DAC modulation period and emits acc_B - acc_A per period.
// Optional ADC_OVR_FLAG_EN adds a per-period over-range flag delivered with each result.
module adc_lockin_rx #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PERIOD = 10000,
  parameter int unsigned HALF   = 5000,
  parameter int unsigned SKIP   = 16,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sync_in,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_ovr,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              result_ovr,
  output logic [7:0]        overrun_cnt,
  output logic              locked
);

  localparam int unsigned IDX_W = $clog2(PERIOD);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StWaitSync, StAcc} state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  s1_data_q;
  logic               s1_sync_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ACC_W-1:0]   acc_a_q, acc_b_q;
  logic [ACC_W-1:0]   cand_q;
  logic               cand_valid_q;
  logic               cand_ovr;

  logic               restart, active, period_end, in_a, in_b;
  logic [IDX_W-1:0]   cur_idx;
  logic [ACC_W-1:0]   sample_ext, acc_a_sum, acc_b_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q <= '0;
      s1_sync_q <= 1'b0;
    end else begin
      s1_data_q <= adc_data;
      s1_sync_q <= sync_in;
    end
  end

  // A sync seen while waiting, or off the expected wrap, starts a fresh period at index 0.
  always_comb begin
    restart = s1_sync_q &&
              ((state_q == StWaitSync) || (state_q == StAcc && idx_q != LastIdx));
    if (restart || idx_q == LastIdx) begin
      cur_idx = '0;
    end else begin
      cur_idx = idx_q + IDX_W'(1);
    end
    active     = enable && ((state_q == StAcc) || (state_q == StWaitSync && s1_sync_q));
    period_end = active && (cur_idx == LastIdx);
    in_a       = (cur_idx >= IDX_W'(SKIP)) && (cur_idx < IDX_W'(HALF));
    in_b       = (cur_idx >= IDX_W'(HALF + SKIP));
    sample_ext = ACC_W'(s1_data_q);
    acc_a_sum  = (restart ? '0 : acc_a_q) + (in_a ? sample_ext : '0);
    acc_b_sum  = (restart ? '0 : acc_b_q) + (in_b ? sample_ext : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      locked       <= 1'b0;
      idx_q        <= '0;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      cand_q       <= '0;
      cand_valid_q <= 1'b0;
    end else begin
      cand_valid_q <= 1'b0;
      if (!enable) begin
        state_q <= StIdle;
        locked  <= 1'b0;
        idx_q   <= '0;
        acc_a_q <= '0;
        acc_b_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StWaitSync;
            locked  <= 1'b0;
          end
          default: begin
            if (active) begin
              state_q <= StAcc;
              locked  <= 1'b1;
              idx_q   <= cur_idx;
              if (period_end) begin
                cand_q       <= acc_b_sum - acc_a_sum;
                cand_valid_q <= 1'b1;
                acc_a_q      <= '0;
                acc_b_q      <= '0;
              end else begin
                acc_a_q <= acc_a_sum;
                acc_b_q <= acc_b_sum;
              end
            end
          end
        endcase
      end
    end
  end

`ifdef ADC_OVR_FLAG_EN
  logic s1_ovr_q, sticky_q, cand_ovr_q, sticky_sum;

  assign sticky_sum = ((restart ? 1'b0 : sticky_q) | (s1_ovr_q && (in_a || in_b)));
  assign cand_ovr   = cand_ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ovr_q   <= 1'b0;
      sticky_q   <= 1'b0;
      cand_ovr_q <= 1'b0;
    end else begin
      s1_ovr_q <= adc_ovr;
      if (!enable) begin
        sticky_q <= 1'b0;
      end else if (active) begin
        sticky_q <= period_end ? 1'b0 : sticky_sum;
        if (period_end) cand_ovr_q <= sticky_sum;
      end
    end
  end
`else
  logic unused_ovr;
  assign unused_ovr = adc_ovr;
  assign cand_ovr   = 1'b0;
`endif

  // A candidate arriving while the held result is stalled is dropped and counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      result_ovr   <= 1'b0;
      overrun_cnt  <= '0;
    end else if (cand_valid_q) begin
      if (!result_valid || result_ready) begin
        result       <= cand_q;
        result_ovr   <= cand_ovr;
        result_valid <= 1'b1;
      end else if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end else if (result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_lockin_rx.sv
// Randomized bench for adc_lockin_rx against a per-period sum model (honours ADC_OVR_FLAG_EN).
module tb_adc_lockin_rx;

  localparam int PERIOD = 10000;
  localparam int HALF   = 5000;
  localparam int SKIP   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sync_in = 1'b0;
  logic [15:0] adc_data = '0;
  logic        adc_ovr = 1'b0;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic        result_ovr;
  logic [7:0]  overrun_cnt;
  logic        locked;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  int last_end_edge = 0;
  logic [32:0] exp_q[$];

  adc_lockin_rx dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sync_in      (sync_in),
    .adc_data     (adc_data),
    .adc_ovr      (adc_ovr),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_ovr   (result_ovr),
    .overrun_cnt  (overrun_cnt),
    .locked       (locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Passive monitor: transfers are scored against the queue, plus hold/latency/pulse rules.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_result = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid && !prev_valid)
        check_eq("latency", 64'(edge_cnt - last_end_edge), 64'd3);
      if (prev_valid && prev_ready)
        check_eq("pulse", 64'(result_valid), 64'd0);
      if (prev_valid && !prev_ready) begin
        check_eq("hold_valid", 64'(result_valid), 64'd1);
        check_eq("hold_result", 64'(result), 64'(prev_result));
      end
      if (result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", 64'(result_valid), 64'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check_eq("result", 64'(result), 64'(e[31:0]));
          check_eq("result_ovr", 64'(result_ovr), 64'(e[32]));
        end
      end
    end
    prev_valid  = result_valid;
    prev_ready  = result_ready;
    prev_result = result;
  end

  // Drives one DAC period (or a truncated one); the model sums the windows per the stream index.
  task automatic run_period(input int mode, input int len, input bit push, input int inj_at,
                            input int drop_at, input int ovr_at, input int rdy_lo_at,
                            input int rdy_hi_at, input int probe_at, input bit probe_exp);
    longint      sum_a = 0;
    longint      sum_b = 0;
    bit          ovr_seen = 1'b0;
    logic [15:0] d;
    logic [63:0] diff;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       d = 16'h1000;
        1:       d = (i < HALF) ? 16'h03FF : 16'h4000;
        default: d = 16'($urandom);
      endcase
      adc_data = d;
      sync_in  = (i == 0) || (i == inj_at);
      adc_ovr  = (i == ovr_at);
      if (drop_at >= 0 && i == drop_at)       enable = 1'b0;
      if (drop_at >= 0 && i == drop_at + 100) enable = 1'b1;
      if (i == rdy_lo_at) result_ready = 1'b0;
      if (i == rdy_hi_at) result_ready = 1'b1;
      if (i == probe_at)  check_eq("locked", 64'(locked), 64'(probe_exp));
      if (i >= SKIP && i < HALF) begin
        sum_a += longint'(d);
        if (adc_ovr) ovr_seen = 1'b1;
      end else if (i >= HALF + SKIP) begin
        sum_b += longint'(d);
        if (adc_ovr) ovr_seen = 1'b1;
      end
      if (i == PERIOD - 1) last_end_edge = edge_cnt;
    end
    diff = 64'(sum_b - sum_a);
`ifndef ADC_OVR_FLAG_EN
    ovr_seen = 1'b0;
`endif
    if (push) exp_q.push_back({ovr_seen, diff[31:0]});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_valid", 64'(result_valid), 64'd0);
    check_eq("rst_ovr", 64'(result_ovr), 64'd0);
    check_eq("rst_overrun", 64'(overrun_cnt), 64'd0);
    check_eq("rst_locked", 64'(locked), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (5) @(posedge clk);

    // mode, len, push, inj, drop, ovr, rdy_lo, rdy_hi, probe, probe_exp
    run_period(0, PERIOD, 1'b1, -1, -1, -1, -1, -1, -1, 1'b0);
    run_period(1, PERIOD, 1'b1, -1, -1, 7000, -1, -1, 100, 1'b1);
    // Backpressure for 2.5 periods: first result held, second dropped, third delivered.
    run_period(1, PERIOD, 1'b1, -1, -1, -1, 100, -1, 200, 1'b1);
    run_period(2, PERIOD, 1'b0, -1, -1, -1, -1, -1, -1, 1'b0);
    run_period(2, PERIOD, 1'b1, -1, -1, 5005, -1, 5000, -1, 1'b0);
    check_eq("overrun_cnt", 64'(overrun_cnt), 64'd1);
    // Misaligned sync at 3000, then a truncated tail; the next full period must be exact.
    run_period(1, 3500, 1'b0, 3000, -1, -1, -1, -1, -1, 1'b0);
    run_period(2, PERIOD, 1'b1, -1, -1, -1, -1, -1, 50, 1'b1);
    // Enable dropped at 6000 and restored 100 cycles later.
    run_period(1, 6200, 1'b0, -1, 6000, -1, -1, -1, 6050, 1'b0);
    run_period(2, PERIOD, 1'b1, -1, -1, -1, -1, -1, 50, 1'b1);
    repeat (10) @(posedge clk);
    check_eq("results_pending", 64'(exp_q.size()), 64'd0);

    run_period(1, 2000, 1'b0, -1, -1, -1, -1, -1, 1000, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("midrst_result", 64'(result), 64'd0);
    check_eq("midrst_valid", 64'(result_valid), 64'd0);
    check_eq("midrst_ovr", 64'(result_ovr), 64'd0);
    check_eq("midrst_overrun", 64'(overrun_cnt), 64'd0);
    check_eq("midrst_locked", 64'(locked), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
